// File: rtl/fetch_queue.sv
// fetch_queue: owns the PC, issues word fetches to instruction memory and buffers the
//   returned words in an in-order queue that feeds decode as {instr_pc, instr}.
// Latency: response -> instr_valid one cycle later (registered queue); with FETCH_BYPASS_EN
//   defined, an empty queue forwards the response word to decode in the same cycle.
// Backpressure: requests are credit limited, (queue count + outstanding) < DEPTH, and a pop
//   from a full queue frees its credit in the same cycle. A redirect flushes the queue and
//   holds requests off until all stale responses have been drained.
// Ports: clk, rst (sync, active high); imem_req/imem_addr/imem_ready request channel;
//   imem_rvalid/imem_rdata in-order responses; redir_valid/redir_pc redirect;
//   instr_valid/instr/instr_pc/dec_ready decode handshake.
// Optional feature macro: FETCH_BYPASS_EN (same-cycle memory-to-decode forwarding).
module fetch_queue #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          DEPTH     = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        dec_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [AW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [AW-1:0]   pcf_wr_q, pcf_wr_d, pcf_rd_q, pcf_rd_d;

  logic [31:0]     q_instr_q [DEPTH];
  logic [31:0]     q_pc_q    [DEPTH];
  // Address of every issued request, popped in response order (kept or dropped alike).
  logic [31:0]     pcf_q     [DEPTH];

  logic            q_valid_w, qpop_w, byp_w, accept_w, push_w, credit_ok_w;
  logic [CW:0]     used_w;
  logic            unused_redir_lsb;

  assign unused_redir_lsb = ^redir_pc[1:0];

  assign q_valid_w = ~rst & (count_q != '0);

`ifdef FETCH_BYPASS_EN
  // Empty queue and nothing left to drop: the response can go straight to decode.
  assign byp_w = ~rst & (count_q == '0) & (discard_q == '0) & imem_rvalid;
`else
  assign byp_w = 1'b0;
`endif

  assign instr_valid = q_valid_w | (byp_w & ~redir_valid);
  assign instr       = byp_w ? imem_rdata        : q_instr_q[head_q];
  assign instr_pc    = byp_w ? pcf_q[pcf_rd_q]   : q_pc_q[head_q];

  // A pop is honoured even when a redirect flushes the rest of the queue.
  assign qpop_w = q_valid_w & dec_ready;

  // Slots already spoken for: buffered words (minus this cycle's pop) plus requests in flight.
  assign used_w      = {1'b0, count_q} + {1'b0, out_q} - {{CW{1'b0}}, qpop_w};
  assign credit_ok_w = used_w < DEPTH_W;

  assign imem_req  = ~rst & (state_q == RUN) & ~redir_valid & credit_ok_w;
  assign imem_addr = pc_q;
  assign accept_w  = imem_req & imem_ready;

  // Kept response is buffered unless a redirect flushes it or decode took it via the bypass.
  assign push_w = imem_rvalid & (discard_q == '0) & ~redir_valid & ~(byp_w & dec_ready);

  always_comb begin
    pc_d      = pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    out_d     = out_q;
    discard_d = discard_q;
    pcf_wr_d  = pcf_wr_q;
    pcf_rd_d  = pcf_rd_q;
    state_d   = state_q;

    if (accept_w) begin
      pc_d     = pc_q + 32'd4;
      pcf_wr_d = pcf_wr_q + AW'(1);
    end
    if (imem_rvalid) begin
      pcf_rd_d = pcf_rd_q + AW'(1);
    end

    if (accept_w && !imem_rvalid)      out_d = out_q + CW'(1);
    else if (!accept_w && imem_rvalid) out_d = out_q - CW'(1);

    if (imem_rvalid && (discard_q != '0)) discard_d = discard_q - CW'(1);

    if (push_w) tail_d = tail_q + AW'(1);
    if (qpop_w) head_d = head_q + AW'(1);
    if (push_w && !qpop_w)      count_d = count_q + CW'(1);
    else if (!push_w && qpop_w) count_d = count_q - CW'(1);

    if (redir_valid) begin
      pc_d      = {redir_pc[31:2], 2'b00};
      count_d   = '0;
      head_d    = tail_q;
      discard_d = out_d;
    end

    case (state_q)
      RUN:     if (redir_valid && (discard_d != '0)) state_d = DRAIN;
      DRAIN:   if (discard_d == '0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_VEC;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      out_q     <= '0;
      discard_q <= '0;
      pcf_wr_q  <= '0;
      pcf_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      out_q     <= out_d;
      discard_q <= discard_d;
      pcf_wr_q  <= pcf_wr_d;
      pcf_rd_q  <= pcf_rd_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters and pointers above.
  always_ff @(posedge clk) begin
    if (push_w) begin
      q_instr_q[tail_q] <= imem_rdata;
      q_pc_q[tail_q]    <= pcf_q[pcf_rd_q];
    end
    if (accept_w) begin
      pcf_q[pcf_wr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a long randomized run against a
// transaction-level model (buffer of delivered words, list of live/killed fetches).
module tb_fetch_queue;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam int          DEPTH     = 2;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        dec_ready = 1'b0;

  fetch_queue #(.RESET_VEC(RESET_VEC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .dec_ready(dec_ready)
  );

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Values applied at the next negedge.
  logic        d_rst = 1'b1, d_ready = 1'b1, d_dec = 1'b1, d_redir = 1'b0;
  logic [31:0] d_rpc = 32'h0;
  int          mem_extra = 0;
  bit          mem_rand = 1'b0;

  // Snapshot of the cycle, taken mid-cycle.
  logic        s_req, s_ivld, s_rvalid;
  logic [31:0] s_addr, s_instr, s_ipc;

  typedef struct { logic [31:0] addr; int age; } mreq_t;
  mreq_t mem_q[$];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468 ^ {a[15:0], a[31:16]};
  endfunction

  // One clock cycle: drive inputs and memory response, sample outputs, advance memory.
  task automatic step();
    @(negedge clk);
    rst         = d_rst;
    imem_ready  = d_ready;
    dec_ready   = d_dec;
    redir_valid = d_redir;
    redir_pc    = d_rpc;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!d_rst && mem_q.size() > 0 && mem_q[0].age >= mem_extra &&
        (!mem_rand || $urandom_range(0, 99) < 60)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(mem_q[0].addr);
    end
    #1;
    s_req    = imem_req;
    s_addr   = imem_addr;
    s_ivld   = instr_valid;
    s_instr  = instr;
    s_ipc    = instr_pc;
    s_rvalid = imem_rvalid;
    @(posedge clk);
    if (d_rst) begin
      mem_q.delete();
    end else begin
      if (s_rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      foreach (mem_q[i]) mem_q[i].age++;
      if (s_req && d_ready) mem_q.push_back('{addr: s_addr, age: 0});
    end
  endtask

  task automatic do_reset();
    d_rst = 1'b1; d_redir = 1'b0; d_dec = 1'b1; d_ready = 1'b1;
    mem_extra = 0; mem_rand = 1'b0;
    step(); step();
    d_rst = 1'b0;
  endtask

  task automatic test_reset();
    d_rst = 1'b1; d_redir = 1'b0; d_dec = 1'b1; d_ready = 1'b1;
    step();
    cmp_cnt++;
    if (s_req !== 1'b0) begin err_cnt++; $display("FAIL reset_req got=%b want=0", s_req); end
    cmp_cnt++;
    if (s_ivld !== 1'b0) begin err_cnt++; $display("FAIL reset_ivld got=%b want=0", s_ivld); end
    d_rst = 1'b0;
    step();
    cmp_cnt++;
    if (s_req !== 1'b1 || s_addr !== RESET_VEC) begin
      err_cnt++; $display("FAIL reset_first_req got=%b/%h want=1/%h", s_req, s_addr, RESET_VEC);
    end
    cmp_cnt++;
    if (s_ivld !== 1'b0) begin err_cnt++; $display("FAIL reset_first_ivld got=%b want=0", s_ivld); end
  endtask

  task automatic test_stream();
    logic [31:0] addrs[$];
    int          cycs[$];
    int          first_v = -1, gaps = 0, nword = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      step();
      if (s_req) begin addrs.push_back(s_addr); cycs.push_back(c); end
      if (s_ivld) begin
        if (first_v < 0) first_v = c;
        cmp_cnt++;
        if (s_ipc !== 32'(nword * 4) || s_instr !== mem_data(32'(nword * 4))) begin
          err_cnt++;
          $display("FAIL stream_word%0d got=%h/%h want=%h/%h", nword, s_ipc, s_instr,
                   32'(nword * 4), mem_data(32'(nword * 4)));
        end
        nword++;
      end else if (first_v >= 0) gaps++;
    end
    cmp_cnt++;
    if (addrs.size() < 3 || addrs[0] !== 32'h0 || addrs[1] !== 32'h4 || addrs[2] !== 32'h8 ||
        cycs[0] != 0 || cycs[1] != 1 || cycs[2] != 2) begin
      err_cnt++; $display("FAIL stream_addrs got=%p want=0,4,8 on cycles 0,1,2", addrs);
    end
    cmp_cnt++;
    if (first_v != (BYP ? 1 : 2)) begin
      err_cnt++; $display("FAIL stream_first_valid got=%0d want=%0d", first_v, BYP ? 1 : 2);
    end
    cmp_cnt++;
    if (gaps != 0) begin err_cnt++; $display("FAIL stream_gaps got=%0d want=0", gaps); end
  endtask

  task automatic test_backpressure();
    int acc = 0, nword = 0;
    do_reset();
    d_dec = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (s_req && d_ready) acc++;
    end
    cmp_cnt++;
    if (acc != DEPTH) begin err_cnt++; $display("FAIL bp_accepts got=%0d want=%0d", acc, DEPTH); end
    cmp_cnt++;
    if (s_req !== 1'b0 || s_ivld !== 1'b1) begin
      err_cnt++; $display("FAIL bp_full got=req%b/ivld%b want=req0/ivld1", s_req, s_ivld);
    end
    d_dec = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (s_ivld) begin
        cmp_cnt++;
        if (s_ipc !== 32'(nword * 4) || s_instr !== mem_data(32'(nword * 4))) begin
          err_cnt++; $display("FAIL bp_order idx=%0d got=%h want=%h", nword, s_ipc, 32'(nword * 4));
        end
        nword++;
      end
    end
    cmp_cnt++;
    if (nword < DEPTH + 4) begin err_cnt++; $display("FAIL bp_drain got=%0d words want>=%0d", nword, DEPTH + 4); end
  endtask

  task automatic test_redirect();
    int acc = 0, drops = 0;
    bit got_req = 1'b0, got_word = 1'b0;
    do_reset();
    mem_extra = 3;
    step(); if (s_req) acc++;
    step(); if (s_req) acc++;
    cmp_cnt++;
    if (acc != 2) begin err_cnt++; $display("FAIL redir_outstanding got=%0d want=2", acc); end
    d_redir = 1'b1; d_rpc = 32'h0000_0103;
    step();
    d_redir = 1'b0;
    cmp_cnt++;
    if (s_req !== 1'b0) begin err_cnt++; $display("FAIL redir_cycle_req got=%b want=0", s_req); end
    for (int c = 0; c < 30 && !got_req; c++) begin
      step();
      if (s_ivld) begin cmp_cnt++; err_cnt++; $display("FAIL redir_stale_word got=%h want=none", s_ipc); end
      if (s_req) begin
        got_req = 1'b1;
        cmp_cnt++;
        if (drops != 2 || s_addr !== 32'h0000_0100) begin
          err_cnt++; $display("FAIL redir_resume got=drops%0d/%h want=drops2/00000100", drops, s_addr);
        end
      end
      if (s_rvalid) drops++;
    end
    if (!got_req) begin cmp_cnt++; err_cnt++; $display("FAIL redir_resume_timeout got=no req want=req"); end
    for (int c = 0; c < 20 && !got_word; c++) begin
      step();
      if (s_ivld) begin
        got_word = 1'b1;
        cmp_cnt++;
        if (s_ipc !== 32'h0000_0100 || s_instr !== mem_data(32'h100)) begin
          err_cnt++; $display("FAIL redir_first_word got=%h/%h want=00000100/%h", s_ipc, s_instr, mem_data(32'h100));
        end
      end
    end
    if (!got_word) begin cmp_cnt++; err_cnt++; $display("FAIL redir_word_timeout got=none want=word"); end
  endtask

  task automatic test_redirect_pop();
    do_reset();
    d_dec = 1'b0;
    step(); step();
    d_redir = 1'b1; d_rpc = 32'h0000_0200; d_dec = 1'b1;
    step();
    d_redir = 1'b0;
    cmp_cnt++;
    if (s_ivld !== 1'b1 || s_ipc !== 32'h0 || s_instr !== mem_data(32'h0)) begin
      err_cnt++; $display("FAIL rpop_delivered got=%b/%h/%h want=1/00000000/%h", s_ivld, s_ipc, s_instr, mem_data(32'h0));
    end
    step();
    cmp_cnt++;
    if (s_ivld !== 1'b0) begin err_cnt++; $display("FAIL rpop_flushed got=%b want=0", s_ivld); end
    cmp_cnt++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_0200) begin
      err_cnt++; $display("FAIL rpop_newpc got=%b/%h want=1/00000200", s_req, s_addr);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    d_redir = 1'b1; d_rpc = 32'hFFFF_FFFE;
    step();
    d_redir = 1'b0;
    step();
    cmp_cnt++;
    if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) begin
      err_cnt++; $display("FAIL wrap_last got=%b/%h want=1/fffffffc", s_req, s_addr);
    end
    step();
    cmp_cnt++;
    if (s_req !== 1'b1 || s_addr !== 32'h0000_0000) begin
      err_cnt++; $display("FAIL wrap_zero got=%b/%h want=1/00000000", s_req, s_addr);
    end
  endtask

  task automatic test_latency();
    do_reset();
    step();
    step();
    cmp_cnt++;
    if (s_ivld !== BYP) begin err_cnt++; $display("FAIL lat_same_cycle got=%b want=%b", s_ivld, BYP); end
    step();
    cmp_cnt++;
    if (s_ivld !== 1'b1 || s_ipc !== (BYP ? 32'h4 : 32'h0)) begin
      err_cnt++; $display("FAIL lat_second got=%b/%h want=1/%h", s_ivld, s_ipc, BYP ? 32'h4 : 32'h0);
    end
  endtask

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; bit live; } fl_t;

  task automatic test_random();
    ent_t        m_buf[$];
    fl_t         m_fl[$];
    fl_t         f;
    logic [31:0] m_pc, e_pc, e_ins;
    bit          dead, byp, qpop, e_req, e_ivld;
    do_reset();
    mem_rand = 1'b1;
    m_pc = RESET_VEC;
    for (int c = 0; c < 10000; c++) begin
      d_rst   = ($urandom_range(0, 999) < 3);
      d_ready = ($urandom_range(0, 99) < 70);
      d_dec   = ($urandom_range(0, 99) < 70);
      d_redir = ($urandom_range(0, 99) < 3);
      d_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
      step();
      if (d_rst) begin
        cmp_cnt++;
        if (s_req !== 1'b0 || s_ivld !== 1'b0) begin
          err_cnt++; $display("FAIL rnd_reset c=%0d got=%b/%b want=0/0", c, s_req, s_ivld);
        end
        m_buf.delete(); m_fl.delete(); m_pc = RESET_VEC;
        continue;
      end
      dead = 1'b0;
      foreach (m_fl[i]) if (!m_fl[i].live) dead = 1'b1;
      byp    = BYP && m_buf.size() == 0 && !dead && s_rvalid && m_fl.size() > 0;
      e_ivld = (m_buf.size() > 0) || (byp && !d_redir);
      e_pc   = 32'h0; e_ins = 32'h0;
      if (m_buf.size() > 0) begin e_pc = m_buf[0].pc; e_ins = m_buf[0].ins; end
      else if (byp) begin e_pc = m_fl[0].addr; e_ins = mem_data(m_fl[0].addr); end
      qpop  = (m_buf.size() > 0) && d_dec;
      e_req = !d_redir && !dead && ((m_buf.size() - int'(qpop) + m_fl.size()) < DEPTH);
      cmp_cnt++;
      if (s_ivld !== e_ivld) begin err_cnt++; $display("FAIL rnd_ivld c=%0d got=%b want=%b", c, s_ivld, e_ivld); end
      if (e_ivld && s_ivld) begin
        cmp_cnt++;
        if (s_ipc !== e_pc || s_instr !== e_ins) begin
          err_cnt++; $display("FAIL rnd_word c=%0d got=%h/%h want=%h/%h", c, s_ipc, s_instr, e_pc, e_ins);
        end
      end
      cmp_cnt++;
      if (s_req !== e_req) begin err_cnt++; $display("FAIL rnd_req c=%0d got=%b want=%b", c, s_req, e_req); end
      if (e_req && s_req) begin
        cmp_cnt++;
        if (s_addr !== m_pc) begin err_cnt++; $display("FAIL rnd_addr c=%0d got=%h want=%h", c, s_addr, m_pc); end
      end
      if (qpop) void'(m_buf.pop_front());
      if (s_rvalid && m_fl.size() > 0) begin
        f = m_fl.pop_front();
        if (f.live && !d_redir && !(byp && d_dec)) m_buf.push_back('{pc: f.addr, ins: mem_data(f.addr)});
      end
      if (e_req && d_ready) begin
        m_fl.push_back('{addr: m_pc, live: 1'b1});
        m_pc = m_pc + 32'd4;
      end
      if (d_redir) begin
        foreach (m_fl[i]) m_fl[i].live = 1'b0;
        m_buf.delete();
        m_pc = {d_rpc[31:2], 2'b00};
      end
    end
    d_rst = 1'b0; d_redir = 1'b0; mem_rand = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_latency();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
